// File: rtl/mc6809_cen_gen.sv
// mc6809_cen_gen: fractional-rate clock-enable generator for an MC6809 core.
// It issues clk_en at num/den of clk and holds MRDY low while a slow device
// completes an access. Strobes that fall due while MRDY is low are saved as
// debt and issued later, so the long-run CPU rate stays at num/den.
//
// Handshake: a CPU cycle targets a slow device when mem_req is high on a cycle
// that issues a strobe in IDLE. That edge drops MRDY. The device then raises
// mem_ok, which is sampled only in WAIT. MRDY returns high one cycle after the
// WAIT state ends, and the DONE state sits between them. A timeout ends WAIT
// early and sets the sticky tout flag.
module mc6809_cen_gen #(
   parameter int CW   = 10,
   parameter int DW   = 3,
   parameter int TMAX = 255
) (
   input  logic          clk,
   input  logic          nRESET,
   input  logic [CW-1:0] num,
   input  logic [CW-1:0] den,
   input  logic          mem_req,
   input  logic          mem_ok,
   output logic          clk_en,
   output logic          MRDY,
   output logic          tout,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   // tcnt only has to reach TMAX-1. When TMAX is 0 it wraps harmlessly.
   localparam int            TW    = (TMAX > 2) ? $clog2(TMAX) : 1;
   localparam bit            TO_EN = (TMAX != 0);
   localparam logic [TW-1:0] TLAST = TW'((TMAX == 0) ? 0 : TMAX - 1);
   localparam logic [DW-1:0] DMAX  = {DW{1'b1}};

   state_t        r_state, w_state_d;
   logic [CW-1:0] r_acc;
   logic [DW-1:0] r_debt, w_debt_d;
   logic [TW-1:0] r_tcnt, w_tcnt_d;
   logic          r_clk_en, w_clk_en_d;
   logic          r_mrdy, w_mrdy_d;
   logic          r_tout, w_tout_d;

   logic [CW:0]   w_sum;
   logic          w_raw;
   logic [CW-1:0] w_acc_d;

   // Phase accumulator. The sum is one bit wider so that num+acc cannot wrap.
   always_comb begin
      w_sum   = {1'b0, r_acc} + {1'b0, num};
      w_raw   = (w_sum >= {1'b0, den});
      w_acc_d = CW'(w_raw ? (w_sum - {1'b0, den}) : w_sum);
   end

   // Strobe, debt and wait-state next-state logic.
   always_comb begin
      w_state_d  = r_state;
      w_debt_d   = r_debt;
      w_tcnt_d   = r_tcnt;
      w_clk_en_d = 1'b0;
      w_mrdy_d   = r_mrdy;
      w_tout_d   = r_tout;
      case (r_state)
         IDLE: begin
            if (w_raw) begin
               w_clk_en_d = 1'b1;
            end else if (r_debt != '0) begin
               w_clk_en_d = 1'b1;
               w_debt_d   = r_debt - 1'b1;
            end
            if (w_clk_en_d && mem_req) begin
               w_state_d = WAIT;
               w_mrdy_d  = 1'b0;
               w_tcnt_d  = '0;
            end
         end
         WAIT: begin
            w_tcnt_d = r_tcnt + 1'b1;
            if (w_raw && (r_debt != DMAX)) w_debt_d = r_debt + 1'b1;
            if (mem_ok) begin
               w_state_d = DONE;
            end else if (TO_EN && (r_tcnt == TLAST)) begin
               w_state_d = DONE;
               w_tout_d  = 1'b1;
            end
         end
         DONE: begin
            if (w_raw && (r_debt != DMAX)) w_debt_d = r_debt + 1'b1;
            w_mrdy_d  = 1'b1;
            w_state_d = IDLE;
         end
         default: begin
            w_state_d = IDLE;
            w_mrdy_d  = 1'b1;
         end
      endcase
   end

   // State register. An asynchronous reset drops any pending access and debt.
   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         r_state  <= IDLE;
         r_acc    <= '0;
         r_debt   <= '0;
         r_tcnt   <= '0;
         r_clk_en <= 1'b0;
         r_mrdy   <= 1'b1;
         r_tout   <= 1'b0;
      end else begin
         r_state  <= w_state_d;
         r_acc    <= w_acc_d;
         r_debt   <= w_debt_d;
         r_tcnt   <= w_tcnt_d;
         r_clk_en <= w_clk_en_d;
         r_mrdy   <= w_mrdy_d;
         r_tout   <= w_tout_d;
      end
   end

   assign clk_en    = r_clk_en;
   assign MRDY      = r_mrdy;
   assign tout      = r_tout;
   assign dbg_state = r_state;

endmodule
